// File: rtl/wb_dsp_slave_regfile.sv
// Wishbone classic slave register file for the DSP engine: per-channel equation addresses,
// write-1 start strobes with overrun detection, done/overrun pending bits and a gated interrupt.
module wb_dsp_slave_regfile #(
  parameter int dw  = 32,
  parameter int aw  = 8,
  parameter int NCH = 4
) (
  input  logic              wb_clk,
  input  logic              wb_rst_n,
  input  logic [aw-1:0]     wb_adr_i,
  input  logic [dw-1:0]     wb_dat_i,
  input  logic [dw/8-1:0]   wb_sel_i,
  input  logic              wb_we_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic [2:0]        wb_cti_i,
  input  logic [1:0]        wb_bte_i,
  output logic [dw-1:0]     wb_dat_o,
  output logic              wb_ack_o,
  output logic              wb_err_o,
  output logic              wb_rty_o,
  input  logic [dw-1:0]     status_i,
  input  logic [NCH-1:0]    done_i,
  input  logic [NCH-1:0]    busy_i,
  output logic [NCH*dw-1:0] eq_addr_o,
  output logic [NCH-1:0]    start_o,
  output logic              interrupt
);

  localparam int IW = aw - 2;

  logic [dw-1:0]  r_eq [NCH];
  logic           r_gie;
  logic [NCH-1:0] r_en_done, r_en_ovr, r_pend_done, r_pend_ovr;
  logic [NCH-1:0] r_done_q, r_start;
  logic           r_ack, r_err, r_irq;
  logic [dw-1:0]  r_dat;

  logic [IW-1:0]  w_idx;
  logic [31:0]    w_idx32;
  logic           w_acc, w_wr, w_rd, w_mapped;
  logic           w_is_ctrl, w_is_stat, w_is_en, w_is_pend;
  logic [NCH-1:0] w_eq_hit, w_start_req, w_w1c_done, w_w1c_ovr, w_done_rise;
  logic [dw-1:0]  w_bmask, w_wdat_m, w_rdata;
  logic           w_unused_ok;

  assign w_unused_ok = ^{wb_cti_i, wb_bte_i, wb_adr_i[1:0]};

  assign w_idx     = wb_adr_i[aw-1:2];
  assign w_idx32   = 32'(w_idx);
  assign w_acc     = wb_cyc_i & wb_stb_i & ~r_ack & ~r_err;
  assign w_wr      = w_acc & wb_we_i;
  assign w_rd      = w_acc & ~wb_we_i;
  assign w_is_ctrl = (w_idx32 == 32'd0);
  assign w_is_stat = (w_idx32 == 32'd1);
  assign w_is_en   = (w_idx32 == 32'd2);
  assign w_is_pend = (w_idx32 == 32'd3);
  assign w_mapped  = w_is_ctrl | w_is_stat | w_is_en | w_is_pend | (|w_eq_hit);

  always_comb begin
    w_eq_hit = '0;
    for (int n = 0; n < NCH; n++) w_eq_hit[n] = (w_idx32 == 32'(4 + n));
  end

  // Every register bit is gated by the select bit of its own byte lane.
  always_comb begin
    w_bmask = '0;
    for (int i = 0; i < dw; i++) w_bmask[i] = wb_sel_i[i/8];
  end
  assign w_wdat_m = wb_dat_i & w_bmask;

  assign w_start_req = (w_wr && w_is_ctrl) ? w_wdat_m[NCH-1:0]    : '0;
  assign w_w1c_done  = (w_wr && w_is_pend) ? w_wdat_m[NCH-1:0]    : '0;
  assign w_w1c_ovr   = (w_wr && w_is_pend) ? w_wdat_m[16 +: NCH]  : '0;
  assign w_done_rise = done_i & ~r_done_q;

  always_comb begin
    w_rdata = '0;
    if (w_is_ctrl) begin
      w_rdata[dw-1] = r_gie;
    end else if (w_is_stat) begin
      w_rdata = status_i;
    end else if (w_is_en) begin
      w_rdata[NCH-1:0]   = r_en_done;
      w_rdata[16 +: NCH] = r_en_ovr;
    end else if (w_is_pend) begin
      w_rdata[NCH-1:0]   = r_pend_done;
      w_rdata[16 +: NCH] = r_pend_ovr;
    end else begin
      for (int n = 0; n < NCH; n++) if (w_eq_hit[n]) w_rdata = r_eq[n];
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_gie       <= 1'b0;
      r_en_done   <= '0;
      r_en_ovr    <= '0;
      r_pend_done <= '0;
      r_pend_ovr  <= '0;
      r_done_q    <= '0;
      r_start     <= '0;
      r_ack       <= 1'b0;
      r_err       <= 1'b0;
      r_irq       <= 1'b0;
      r_dat       <= '0;
      for (int n = 0; n < NCH; n++) r_eq[n] <= '0;
    end else begin
      r_ack    <= w_acc & w_mapped;
      r_err    <= w_acc & ~w_mapped;
      if (w_rd) r_dat <= w_rdata;
      r_start  <= w_start_req & ~busy_i;
      r_done_q <= done_i;
      // Set terms are OR-ed after the clear so a coincident event survives the W1C.
      r_pend_done <= (r_pend_done & ~w_w1c_done) | w_done_rise;
      r_pend_ovr  <= (r_pend_ovr & ~w_w1c_ovr) | (w_start_req & busy_i);
      r_irq <= r_gie & ((|(r_pend_done & r_en_done)) | (|(r_pend_ovr & r_en_ovr)));
      if (w_wr && w_is_ctrl && wb_sel_i[dw/8-1]) r_gie <= wb_dat_i[dw-1];
      if (w_wr && w_is_en) begin
        r_en_done <= (r_en_done & ~w_bmask[NCH-1:0]) | w_wdat_m[NCH-1:0];
        r_en_ovr  <= (r_en_ovr & ~w_bmask[16 +: NCH]) | w_wdat_m[16 +: NCH];
      end
      for (int n = 0; n < NCH; n++)
        for (int b = 0; b < dw/8; b++)
          if (w_wr && w_eq_hit[n] && wb_sel_i[b]) r_eq[n][8*b +: 8] <= wb_dat_i[8*b +: 8];
    end
  end

  always_comb begin
    eq_addr_o = '0;
    for (int n = 0; n < NCH; n++) eq_addr_o[n*dw +: dw] = r_eq[n];
  end

  assign wb_dat_o  = r_dat;
  assign wb_ack_o  = r_ack;
  assign wb_err_o  = r_err;
  assign wb_rty_o  = 1'b0;
  assign start_o   = r_start;
  assign interrupt = r_irq;

endmodule

// File: tb/tb_wb_dsp_slave_regfile.sv
// Bench for wb_dsp_slave_regfile: directed register-map scenarios followed by random
// bus traffic, all checked against a transaction-level model of the register map.
module tb_wb_dsp_slave_regfile;

  localparam int NCH = 4;
  localparam logic [31:0] ENMASK = 32'h000F_000F;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]       adr;
  logic [31:0]      dat_i, status;
  logic [3:0]       sel;
  logic             we, cyc, stb;
  logic [2:0]       cti;
  logic [1:0]       bte;
  logic [31:0]      dat_o;
  logic             ack, err, rty, irq;
  logic [NCH-1:0]   done, busy, start;
  logic [NCH*32-1:0] eq_addr;

  wb_dsp_slave_regfile #(.dw(32), .aw(8), .NCH(NCH)) dut (
    .wb_clk(clk), .wb_rst_n(rst_n), .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_sel_i(sel),
    .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_cti_i(cti), .wb_bte_i(bte),
    .wb_dat_o(dat_o), .wb_ack_o(ack), .wb_err_o(err), .wb_rty_o(rty),
    .status_i(status), .done_i(done), .busy_i(busy), .eq_addr_o(eq_addr),
    .start_o(start), .interrupt(irq)
  );

  // reference model state
  logic [31:0]    m_eq [NCH];
  logic           m_gie;
  logic [31:0]    m_en, m_pend, m_last_rd;
  logic [NCH-1:0] m_done_prev;
  logic [NCH-1:0] start_seen;
  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic model_irq();
    return m_gie && ((m_pend & m_en) != 32'd0);
  endfunction

  function automatic logic [127:0] model_eq_flat();
    logic [127:0] f;
    for (int n = 0; n < NCH; n++) f[n*32 +: 32] = m_eq[n];
    return f;
  endfunction

  // driver: one classic cycle, plus the model's view of what it must do
  task automatic xfer(input logic [7:0] a, input logic w, input logic [31:0] d,
                      input logic [3:0] s, input logic [NCH-1:0] bz,
                      input logic [NCH-1:0] dn, output logic [31:0] rd);
    int widx;
    logic mapped, irq_before;
    logic [31:0] m, dm, st, exp_rd;
    logic [NCH-1:0] rise, req;
    widx = int'(a[7:2]);
    mapped = widx < 4 + NCH;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{s[b]}};
    dm = d & m;
    st = $urandom;
    irq_before = model_irq();
    exp_rd = 32'd0;
    if (mapped) begin
      case (widx)
        0: exp_rd = {m_gie, 31'd0};
        1: exp_rd = st;
        2: exp_rd = m_en;
        3: exp_rd = m_pend;
        default: exp_rd = m_eq[widx-4];
      endcase
    end
    if (!w) m_last_rd = exp_rd;
    rise = dn & ~m_done_prev;
    m_done_prev = dn;
    req = '0;
    if (w && mapped) begin
      case (widx)
        0: begin
          if (s[3]) m_gie = d[31];
          req = dm[NCH-1:0];
        end
        1: ;
        2: m_en = ((m_en & ~m) | dm) & ENMASK;
        3: m_pend = m_pend & ~(dm & ENMASK);
        default: m_eq[widx-4] = (m_eq[widx-4] & ~m) | dm;
      endcase
    end
    m_pend = m_pend | 32'(rise) | (32'(req & bz) << 16);

    @(negedge clk);
    adr = a; we = w; dat_i = d; sel = s; busy = bz; done = dn; status = st;
    cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    check("ack", ack, mapped);
    check("err", err, !mapped);
    check("dat", dat_o, m_last_rd);
    check("start", start, req & ~bz);
    check("irq_pre", irq, irq_before);
    start_seen = start;
    rd = dat_o;
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    check("ack_drop", {ack, err}, 2'b00);
    check("start_drop", start, '0);
    check("irq_post", irq, model_irq());
    check("eq_out", eq_addr, model_eq_flat());
  endtask

  logic [31:0] rd;
  logic [NCH-1:0] cur_done;

  initial begin
    adr = '0; dat_i = '0; sel = '0; we = 1'b0; cyc = 1'b0; stb = 1'b0;
    cti = '0; bte = '0; status = '0; done = '0; busy = '0;
    m_gie = 1'b0; m_en = '0; m_pend = '0; m_last_rd = '0; m_done_prev = '0;
    for (int n = 0; n < NCH; n++) m_eq[n] = '0;
    cur_done = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", {ack, err, rty}, 3'b000);
    check("rst_start_irq", {start, irq}, 5'b0);
    check("rst_dat", dat_o, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // reset contents of every mapped word
    for (int i = 0; i < 4 + NCH; i++) xfer(8'(4*i), 1'b0, 32'd0, 4'hF, '0, '0, rd);

    // byte-lane write to EQ_ADDR[2]
    xfer(8'h18, 1'b1, 32'hDEAD_BEEF, 4'b0101, '0, '0, rd);
    xfer(8'h18, 1'b0, 32'd0, 4'hF, '0, '0, rd);
    check("t2_eq2", rd, 32'h00AD_00EF);
    xfer(8'h14, 1'b0, 32'd0, 4'hF, '0, '0, rd);
    check("t2_eq1", rd, 32'd0);

    // start two channels and set GIE
    xfer(8'h00, 1'b1, 32'h8000_0005, 4'hF, '0, '0, rd);
    check("t3_start", start_seen, 4'b0101);
    xfer(8'h00, 1'b0, 32'd0, 4'hF, '0, '0, rd);
    check("t3_ctrl", rd, 32'h8000_0000);

    // start on a busy channel -> overrun
    xfer(8'h00, 1'b1, 32'h0000_0002, 4'b0001, 4'b0010, '0, rd);
    check("t4_nostart", start_seen, 4'b0000);
    xfer(8'h0C, 1'b0, 32'd0, 4'hF, '0, '0, rd);
    check("t4_pend", rd, 32'h0002_0000);
    xfer(8'h08, 1'b1, 32'h0002_0000, 4'hF, '0, '0, rd);
    check("t4_irq", irq, 1'b1);

    // done rise coinciding with W1C: set wins
    xfer(8'h0C, 1'b1, 32'hFFFF_FFFF, 4'hF, '0, '0, rd);
    xfer(8'h08, 1'b1, 32'h0000_0008, 4'hF, '0, '0, rd);
    xfer(8'h0C, 1'b1, 32'h0000_0008, 4'hF, '0, 4'b1000, rd);
    xfer(8'h0C, 1'b0, 32'd0, 4'hF, '0, 4'b1000, rd);
    check("t5_keep", rd, 32'h0000_0008);
    check("t5_irq", irq, 1'b1);
    xfer(8'h0C, 1'b1, 32'h0000_0008, 4'hF, '0, 4'b1000, rd);
    check("t5_clr_irq", irq, 1'b0);
    cur_done = 4'b1000;

    // unmapped accesses
    xfer(8'(16 + 4*NCH), 1'b0, 32'd0, 4'hF, '0, cur_done, rd);
    check("t6_rd0", rd, 32'd0);
    xfer(8'hFC, 1'b1, 32'hFFFF_FFFF, 4'hF, '0, cur_done, rd);
    xfer(8'hFC, 1'b0, 32'd0, 4'hF, '0, cur_done, rd);
    check("t6_rd1", rd, 32'd0);

    // random traffic
    for (int t = 0; t < 300; t++) begin
      logic [7:0] a;
      if ($urandom_range(0, 9) < 8) a = 8'(4 * $urandom_range(0, 3 + NCH));
      else a = 8'(4 * $urandom_range(4 + NCH, 63));
      a[1:0] = 2'($urandom);
      if ($urandom_range(0, 3) == 0) cur_done = NCH'($urandom);
      xfer(a, 1'($urandom), $urandom, 4'($urandom), NCH'($urandom), cur_done, rd);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
